// File: rtl/sram_arbiter.sv
// -----------------------------------------------------------------------------
// sram_arbiter
//
// Purpose:
//   Shares one single-port SRAM between an instruction-fetch port and a
//   load/store port. At most one transaction is in flight at a time. A request
//   is accepted in IDLE, or in the completion cycle of the current transaction,
//   so the SRAM can take a new request every RD_LAT cycles. Data requests win
//   by default. Instruction fetches are protected from starvation: after
//   STARVE_MAX consecutive data grants with a fetch pending, the fetch wins.
//
// Parameters:
//   RD_LAT      SRAM read latency in cycles (1..4)
//   STARVE_MAX  consecutive data grants tolerated while inst_req is pending
//
// Ports:
//   clk, resetn                       clock, asynchronous active-low reset
//   inst_req/inst_addr                fetch request and address
//   inst_addr_ok/inst_data_ok         fetch accepted / fetch data valid
//   inst_rdata                        fetch read data (raw SRAM word)
//   data_req/wr/wstrb/addr/wdata      load/store request
//   data_addr_ok/data_data_ok         load/store accepted / complete
//   data_rdata                        load read data (raw SRAM word)
//   sram_en/we/addr/wdata             SRAM command, valid only in accept cycle
//   sram_rdata                        SRAM read data, RD_LAT cycles after en
// -----------------------------------------------------------------------------
module sram_arbiter #(
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        sram_en,
    output logic [3:0]  sram_we,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    localparam logic [0:0] OWN_INST = 1'b0;
    localparam logic [0:0] OWN_DATA = 1'b1;

    localparam int              SW         = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0]   STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [2:0]      LAT        = 3'(RD_LAT);

    logic [0:0]    state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [0:0]    owner_q, owner_d;
    logic [SW-1:0] starve_q, starve_d;

    logic can_accept;
    logic starve_hit;
    logic data_win;
    logic inst_win;
    logic accept;
    logic done;

    // cnt==1 in WAIT is the completion cycle; the slot is free again there.
    assign can_accept = (state_q == ST_IDLE) || (cnt_q == 3'd1);
    assign starve_hit = inst_req && (starve_q == STARVE_LIM);
    assign data_win   = data_req && !starve_hit;
    assign inst_win   = inst_req && !data_win;
    // Gating with resetn keeps every output at 0 while reset is held, even
    // though the (reset) IDLE state would otherwise allow an accept.
    assign accept     = resetn && can_accept && (inst_req || data_req);
    assign done       = resetn && (state_q == ST_WAIT) && (cnt_q == 3'd1);

    // Handshake outputs
    assign inst_addr_ok = accept && inst_win;
    assign data_addr_ok = accept && data_win;
    assign inst_data_ok = done && (owner_q == OWN_INST);
    assign data_data_ok = done && (owner_q == OWN_DATA);

    // Read data passes straight through; the owner's data_ok qualifies it.
    assign inst_rdata = resetn ? sram_rdata : 32'h0;
    assign data_rdata = resetn ? sram_rdata : 32'h0;

    // SRAM command is driven only in the accept cycle, zero otherwise.
    assign sram_en    = accept;
    assign sram_addr  = !accept ? 32'h0 : (data_win ? data_addr : inst_addr);
    assign sram_we    = (accept && data_win && data_wr) ? data_wstrb : 4'b0000;
    assign sram_wdata = (accept && data_win) ? data_wdata : 32'h0;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        owner_d  = owner_q;
        starve_d = starve_q;

        if (accept) begin
            state_d = ST_WAIT;
            cnt_d   = LAT;
            owner_d = data_win ? OWN_DATA : OWN_INST;
        end else if (state_q == ST_WAIT) begin
            if (cnt_q == 3'd1) begin
                state_d = ST_IDLE;
                cnt_d   = 3'd0;
            end else begin
                cnt_d = cnt_q - 3'd1;
            end
        end

        // Starvation counter: counts data grants made over a waiting fetch.
        if (!inst_req || (accept && inst_win)) begin
            starve_d = '0;
        end else if (accept && data_win && (starve_q != STARVE_LIM)) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 3'd0;
            owner_q  <= OWN_INST;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            owner_q  <= owner_d;
            starve_q <= starve_d;
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
module tb_sram_arbiter;

    logic        clk;
    logic        resetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        data_req;
    logic        data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] sram_rdata;

    // Outputs of the three instances (index = RD_LAT)
    logic        inst_addr_ok_w [1:3];
    logic        inst_data_ok_w [1:3];
    logic [31:0] inst_rdata_w   [1:3];
    logic        data_addr_ok_w [1:3];
    logic        data_data_ok_w [1:3];
    logic [31:0] data_rdata_w   [1:3];
    logic        sram_en_w      [1:3];
    logic [3:0]  sram_we_w      [1:3];
    logic [31:0] sram_addr_w    [1:3];
    logic [31:0] sram_wdata_w   [1:3];

    int errors = 0;
    int checks = 0;

    sram_arbiter #(.RD_LAT(1), .STARVE_MAX(4)) dut1 (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok_w[1]), .inst_data_ok(inst_data_ok_w[1]), .inst_rdata(inst_rdata_w[1]),
        .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok_w[1]), .data_data_ok(data_data_ok_w[1]), .data_rdata(data_rdata_w[1]),
        .sram_en(sram_en_w[1]), .sram_we(sram_we_w[1]), .sram_addr(sram_addr_w[1]),
        .sram_wdata(sram_wdata_w[1]), .sram_rdata(sram_rdata)
    );

    sram_arbiter #(.RD_LAT(2), .STARVE_MAX(4)) dut2 (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok_w[2]), .inst_data_ok(inst_data_ok_w[2]), .inst_rdata(inst_rdata_w[2]),
        .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok_w[2]), .data_data_ok(data_data_ok_w[2]), .data_rdata(data_rdata_w[2]),
        .sram_en(sram_en_w[2]), .sram_we(sram_we_w[2]), .sram_addr(sram_addr_w[2]),
        .sram_wdata(sram_wdata_w[2]), .sram_rdata(sram_rdata)
    );

    sram_arbiter #(.RD_LAT(3), .STARVE_MAX(4)) dut3 (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok_w[3]), .inst_data_ok(inst_data_ok_w[3]), .inst_rdata(inst_rdata_w[3]),
        .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok_w[3]), .data_data_ok(data_data_ok_w[3]), .data_rdata(data_rdata_w[3]),
        .sram_en(sram_en_w[3]), .sram_we(sram_we_w[3]), .sram_addr(sram_addr_w[3]),
        .sram_wdata(sram_wdata_w[3]), .sram_rdata(sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        inst_req   = 1'b0;
        inst_addr  = 32'h0;
        data_req   = 1'b0;
        data_wr    = 1'b0;
        data_wstrb = 4'h0;
        data_addr  = 32'h0;
        data_wdata = 32'h0;
    endtask

    // Returns just after reset release; the next edge may accept.
    task automatic do_reset();
        nxt();
        resetn = 1'b0;
        clear_inputs();
        nxt();
        resetn = 1'b1;
    endtask

    bit exp_d [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    int dgrants;

    initial begin
        clear_inputs();
        resetn     = 1'b0;
        sram_rdata = 32'h1111_2222;

        // ---- Outputs held at 0 in reset even with a request pending ----
        data_req  = 1'b1;
        data_addr = 32'h0000_0500;
        nxt();
        @(negedge clk);
        chk("rst_sram_en",   32'(sram_en_w[1]), 32'h0);
        chk("rst_daddr_ok",  32'(data_addr_ok_w[1]), 32'h0);
        chk("rst_sram_addr", sram_addr_w[1], 32'h0);
        chk("rst_drdata",    data_rdata_w[1], 32'h0);
        $display("txn reset_hold: checked");
        nxt();
        clear_inputs();
        resetn = 1'b1;

        // ---- Idle: nothing asserted ----
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_en",   32'(sram_en_w[1]), 32'h0);
            chk("idle_we",   32'(sram_we_w[1]), 32'h0);
            chk("idle_aok",  32'({inst_addr_ok_w[1], data_addr_ok_w[1]}), 32'h0);
            chk("idle_dok",  32'({inst_data_ok_w[1], data_data_ok_w[1]}), 32'h0);
            $display("txn idle cycle %0d: checked", i);
            nxt();
        end

        // ---- Single load, RD_LAT=1 ----
        data_req  = 1'b1;
        data_wr   = 1'b0;
        data_addr = 32'h0000_1000;
        @(negedge clk);
        chk("ld_daddr_ok", 32'(data_addr_ok_w[1]), 32'h1);
        chk("ld_iaddr_ok", 32'(inst_addr_ok_w[1]), 32'h0);
        chk("ld_en",       32'(sram_en_w[1]), 32'h1);
        chk("ld_addr",     sram_addr_w[1], 32'h0000_1000);
        chk("ld_we",       32'(sram_we_w[1]), 32'h0);
        nxt();
        data_req   = 1'b0;
        sram_rdata = 32'hCAFE_0001;
        @(negedge clk);
        chk("ld_ddata_ok", 32'(data_data_ok_w[1]), 32'h1);
        chk("ld_idata_ok", 32'(inst_data_ok_w[1]), 32'h0);
        chk("ld_rdata",    data_rdata_w[1], 32'hCAFE_0001);
        chk("ld_en_after", 32'(sram_en_w[1]), 32'h0);
        nxt();
        @(negedge clk);
        chk("ld_dok_drop", 32'(data_data_ok_w[1]), 32'h0);
        $display("txn single_load addr=0x1000: checked");

        // ---- Contention, RD_LAT=1: expected D,D,D,D,I,D,D ----
        do_reset();
        inst_req  = 1'b1;
        inst_addr = 32'h0000_0040;
        dgrants   = 0;
        for (int i = 0; i < 7; i++) begin
            data_req  = (dgrants < 6);
            data_addr = 32'h0000_0100 + 32'(dgrants * 4);
            @(negedge clk);
            chk("arb_daddr_ok", 32'(data_addr_ok_w[1]), 32'(exp_d[i]));
            chk("arb_iaddr_ok", 32'(inst_addr_ok_w[1]), 32'(!exp_d[i]));
            chk("arb_sram_addr", sram_addr_w[1], exp_d[i] ? data_addr : inst_addr);
            if (i > 0) begin
                chk("arb_ddata_ok", 32'(data_data_ok_w[1]), 32'(exp_d[i-1]));
                chk("arb_idata_ok", 32'(inst_data_ok_w[1]), 32'(!exp_d[i-1]));
            end
            $display("txn arb grant %0d: expected %s", i, exp_d[i] ? "D" : "I");
            if (exp_d[i]) dgrants++;
            nxt();
        end
        inst_req = 1'b0;
        data_req = 1'b0;
        @(negedge clk);
        chk("arb_last_dok", 32'(data_data_ok_w[1]), 32'h1);
        chk("arb_last_aok", 32'({inst_addr_ok_w[1], data_addr_ok_w[1]}), 32'h0);

        // ---- Store, RD_LAT=2, with a fetch waiting behind it ----
        do_reset();
        inst_req   = 1'b1;
        inst_addr  = 32'h0000_0080;
        data_req   = 1'b1;
        data_wr    = 1'b1;
        data_wstrb = 4'b0011;
        data_addr  = 32'h0000_2000;
        data_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("st_daddr_ok", 32'(data_addr_ok_w[2]), 32'h1);
        chk("st_iaddr_ok", 32'(inst_addr_ok_w[2]), 32'h0);
        chk("st_we",       32'(sram_we_w[2]), 32'h3);
        chk("st_wdata",    sram_wdata_w[2], 32'hDEAD_BEEF);
        chk("st_addr",     sram_addr_w[2], 32'h0000_2000);
        nxt();
        data_req = 1'b0;
        @(negedge clk);
        chk("st_t1_en",    32'(sram_en_w[2]), 32'h0);
        chk("st_t1_we",    32'(sram_we_w[2]), 32'h0);
        chk("st_t1_wdata", sram_wdata_w[2], 32'h0);
        chk("st_t1_iaok",  32'(inst_addr_ok_w[2]), 32'h0);
        chk("st_t1_dok",   32'(data_data_ok_w[2]), 32'h0);
        nxt();
        @(negedge clk);
        chk("st_t2_dok",   32'(data_data_ok_w[2]), 32'h1);
        chk("st_t2_iaok",  32'(inst_addr_ok_w[2]), 32'h1);
        chk("st_t2_addr",  sram_addr_w[2], 32'h0000_0080);
        chk("st_t2_we",    32'(sram_we_w[2]), 32'h0);
        nxt();
        inst_req = 1'b0;
        @(negedge clk);
        chk("st_t3_idok",  32'(inst_data_ok_w[2]), 32'h0);
        nxt();
        @(negedge clk);
        chk("st_t4_idok",  32'(inst_data_ok_w[2]), 32'h1);
        chk("st_t4_ddok",  32'(data_data_ok_w[2]), 32'h0);
        $display("txn store wstrb=0011 wdata=DEADBEEF rd_lat=2: checked");

        // ---- Store with zero byte enables, RD_LAT=2 ----
        nxt();
        data_req   = 1'b1;
        data_wr    = 1'b1;
        data_wstrb = 4'b0000;
        data_addr  = 32'h0000_2004;
        data_wdata = 32'h1234_5678;
        @(negedge clk);
        chk("st0_daok", 32'(data_addr_ok_w[2]), 32'h1);
        chk("st0_en",   32'(sram_en_w[2]), 32'h1);
        chk("st0_we",   32'(sram_we_w[2]), 32'h0);
        nxt();
        data_req = 1'b0;
        nxt();
        @(negedge clk);
        chk("st0_ddok", 32'(data_data_ok_w[2]), 32'h1);
        $display("txn store wstrb=0000 rd_lat=2: checked");

        // ---- Back-to-back fetches, RD_LAT=1 ----
        do_reset();
        for (int k = 0; k < 3; k++) begin
            inst_req   = 1'b1;
            inst_addr  = 32'(k * 4);
            sram_rdata = 32'hA000_0000 + 32'(k);
            @(negedge clk);
            chk("bb_iaok", 32'(inst_addr_ok_w[1]), 32'h1);
            chk("bb_addr", sram_addr_w[1], 32'(k * 4));
            chk("bb_idok", 32'(inst_data_ok_w[1]), 32'(k > 0));
            chk("bb_irdata", inst_rdata_w[1], 32'hA000_0000 + 32'(k));
            $display("txn fetch addr=0x%0h: checked", k * 4);
            nxt();
        end
        inst_req = 1'b0;
        @(negedge clk);
        chk("bb_last_idok", 32'(inst_data_ok_w[1]), 32'h1);
        chk("bb_last_iaok", 32'(inst_addr_ok_w[1]), 32'h0);
        nxt();
        @(negedge clk);
        chk("bb_idle_idok", 32'(inst_data_ok_w[1]), 32'h0);

        // ---- Reset in WAIT, RD_LAT=3 ----
        do_reset();
        data_req  = 1'b1;
        data_wr   = 1'b0;
        data_addr = 32'h0000_3000;
        @(negedge clk);
        chk("rw_daok", 32'(data_addr_ok_w[3]), 32'h1);
        nxt();
        data_req   = 1'b0;
        resetn     = 1'b0;
        sram_rdata = 32'h5555_AAAA;
        @(negedge clk);
        chk("rw_rst_en",   32'(sram_en_w[3]), 32'h0);
        chk("rw_rst_dok",  32'({inst_data_ok_w[3], data_data_ok_w[3]}), 32'h0);
        chk("rw_rst_rd",   data_rdata_w[3], 32'h0);
        nxt();
        resetn    = 1'b1;
        inst_req  = 1'b1;
        inst_addr = 32'h0000_00C0;
        @(negedge clk);
        chk("rw_rel_iaok", 32'(inst_addr_ok_w[3]), 32'h1);
        chk("rw_rel_addr", sram_addr_w[3], 32'h0000_00C0);
        nxt();
        inst_req = 1'b0;
        @(negedge clk);
        chk("rw_t3_ddok", 32'(data_data_ok_w[3]), 32'h0);
        chk("rw_t3_idok", 32'(inst_data_ok_w[3]), 32'h0);
        nxt();
        @(negedge clk);
        chk("rw_t4_idok", 32'(inst_data_ok_w[3]), 32'h0);
        nxt();
        @(negedge clk);
        chk("rw_t5_idok", 32'(inst_data_ok_w[3]), 32'h1);
        chk("rw_t5_ddok", 32'(data_data_ok_w[3]), 32'h0);
        $display("txn reset_in_wait rd_lat=3: checked");

        nxt();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
